// File: rtl/mshr_refill_ctrl_pkg.sv
// Shared cache-side definitions: refill FSM encoding and index-width rule,
// reused by the MSHR file and the refill controller.
package mshr_refill_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_DATA   = 3'd2,
    ST_RETIRE = 3'd3,
    ST_DRAIN  = 3'd4
  } refill_state_e;

  // Index width for an n-entry structure; never narrower than 1 bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mshr_refill_ctrl_rr_arbiter.sv
// Round-robin arbiter: searches from the entry after the last accepted grant.
module rr_arbiter
  import mshr_refill_ctrl_pkg::*;
#(
  parameter  int N  = 8,
  localparam int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          accept,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_id
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] idx;

  // Walk offsets high to low so the closest requester to ptr_q wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = ptr_q;
    idx       = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = ptr_q + IW'(i);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (accept && gnt_valid) begin
      ptr_q <= gnt_id + IW'(1);
    end
  end

endmodule

// File: rtl/mshr_refill_ctrl.sv
// Line refill controller: picks one pending MSHR, issues a line read, streams
// beats into the cache array with requester wakeups, then retires the entry.
module mshr_refill_ctrl
  import mshr_refill_ctrl_pkg::*;
#(
  parameter  int NUM_MSHR       = 8,
  parameter  int ADDR_WIDTH     = 32,
  parameter  int DATA_WIDTH     = 32,
  parameter  int WORDS_PER_LINE = 16,
  localparam int ID_W           = idx_w(NUM_MSHR),
  localparam int OFF_W          = idx_w(WORDS_PER_LINE)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_MSHR-1:0]                 mshr_valid,
  input  logic [NUM_MSHR*ADDR_WIDTH-1:0]      mshr_addr_flat,
  input  logic [NUM_MSHR*WORDS_PER_LINE-1:0]  mshr_word_mask_flat,
  output logic                                retire_req,
  output logic [ID_W-1:0]                     retire_id,
  output logic                                mem_req_valid,
  input  logic                                mem_req_ready,
  output logic [ADDR_WIDTH-1:0]               mem_req_addr,
  input  logic                                mem_resp_valid,
  output logic                                mem_resp_ready,
  input  logic [DATA_WIDTH-1:0]               mem_resp_data,
  input  logic                                mem_resp_last,
  output logic                                fill_valid,
  output logic [ADDR_WIDTH-1:0]               fill_addr,
  output logic [DATA_WIDTH-1:0]               fill_data,
  output logic                                fill_critical,
  output logic                                busy,
  output logic                                err_protocol
);

  refill_state_e         state_q;
  logic [ID_W-1:0]       id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [OFF_W-1:0]      beat_q;
  logic                  mem_req_valid_q, mem_resp_ready_q, retire_q, err_q;
  logic                  fill_valid_q, fill_crit_q;
  logic [ADDR_WIDTH-1:0] fill_addr_q;
  logic [DATA_WIDTH-1:0] fill_data_q;

  logic                  gnt_valid;
  logic [ID_W-1:0]       gnt_id;
  logic                  last_beat;
  logic                  crit_live;
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_MSHR];

  for (genvar g = 0; g < NUM_MSHR; g++) begin : g_addr
    assign addr_arr[g] = mshr_addr_flat[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  rr_arbiter #(.N(NUM_MSHR)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (mshr_valid),
    .accept    (state_q == ST_IDLE),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign last_beat = (beat_q == OFF_W'(WORDS_PER_LINE - 1));
  // Live mask read so words coalesced mid-refill still get their wakeup.
  assign crit_live = mshr_word_mask_flat[{id_q, beat_q}];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      id_q             <= '0;
      addr_q           <= '0;
      beat_q           <= '0;
      mem_req_valid_q  <= 1'b0;
      mem_resp_ready_q <= 1'b0;
      fill_valid_q     <= 1'b0;
      fill_addr_q      <= '0;
      fill_data_q      <= '0;
      fill_crit_q      <= 1'b0;
      retire_q         <= 1'b0;
      err_q            <= 1'b0;
    end else begin
      fill_valid_q <= 1'b0;
      retire_q     <= 1'b0;
      case (state_q)
        ST_IDLE: if (gnt_valid) begin
          id_q            <= gnt_id;
          addr_q          <= addr_arr[gnt_id];
          beat_q          <= '0;
          mem_req_valid_q <= 1'b1;
          state_q         <= ST_REQ;
        end
        ST_REQ: if (mem_req_ready) begin
          mem_req_valid_q  <= 1'b0;
          mem_resp_ready_q <= 1'b1;
          state_q          <= ST_DATA;
        end
        ST_DATA: if (mem_resp_valid) begin
          fill_valid_q <= 1'b1;
          fill_addr_q  <= addr_q + ADDR_WIDTH'({beat_q, 2'b00});
          fill_data_q  <= mem_resp_data;
          fill_crit_q  <= crit_live;
          if (mem_resp_last != last_beat) err_q <= 1'b1;
          // The beat counter, not mem_resp_last, decides completion.
          if (last_beat) begin
            beat_q           <= '0;
            mem_resp_ready_q <= 1'b0;
            retire_q         <= 1'b1;
            state_q          <= ST_RETIRE;
          end else begin
            beat_q <= beat_q + OFF_W'(1);
          end
        end
        ST_RETIRE: state_q <= ST_DRAIN;
        ST_DRAIN:  state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign mem_req_valid  = mem_req_valid_q;
  assign mem_req_addr   = addr_q;
  assign mem_resp_ready = mem_resp_ready_q;
  assign fill_valid     = fill_valid_q;
  assign fill_addr      = fill_addr_q;
  assign fill_data      = fill_data_q;
  assign fill_critical  = fill_crit_q;
  assign retire_req     = retire_q;
  assign retire_id      = id_q;
  assign err_protocol   = err_q;

endmodule

// File: tb/tb_mshr_refill_ctrl.sv
// Directed bench for mshr_refill_ctrl; the bench plays both MSHR file and memory.
module tb_mshr_refill_ctrl;

  localparam int N   = 8;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int WPL = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      mshr_valid;
  logic [N*AW-1:0]   mshr_addr_flat;
  logic [N*WPL-1:0]  mshr_word_mask_flat;
  logic              retire_req;
  logic [2:0]        retire_id;
  logic              mem_req_valid, mem_req_ready;
  logic [AW-1:0]     mem_req_addr;
  logic              mem_resp_valid, mem_resp_ready, mem_resp_last;
  logic [DW-1:0]     mem_resp_data;
  logic              fill_valid, fill_critical, busy, err_protocol;
  logic [AW-1:0]     fill_addr;
  logic [DW-1:0]     fill_data;

  int tests = 0;
  int fails = 0;

  mshr_refill_ctrl #(.NUM_MSHR(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_LINE(WPL)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .mshr_valid          (mshr_valid),
    .mshr_addr_flat      (mshr_addr_flat),
    .mshr_word_mask_flat (mshr_word_mask_flat),
    .retire_req          (retire_req),
    .retire_id           (retire_id),
    .mem_req_valid       (mem_req_valid),
    .mem_req_ready       (mem_req_ready),
    .mem_req_addr        (mem_req_addr),
    .mem_resp_valid      (mem_resp_valid),
    .mem_resp_ready      (mem_resp_ready),
    .mem_resp_data       (mem_resp_data),
    .mem_resp_last       (mem_resp_last),
    .fill_valid          (fill_valid),
    .fill_addr           (fill_addr),
    .fill_data           (fill_data),
    .fill_critical       (fill_critical),
    .busy                (busy),
    .err_protocol        (err_protocol)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic set_entry(input int id, input logic [31:0] a, input logic [15:0] m);
    mshr_valid[id]                     = 1'b1;
    mshr_addr_flat[id*AW +: AW]        = a;
    mshr_word_mask_flat[id*WPL +: WPL] = m;
  endtask

  // One refill of entry id; rst_beat >= 0 fires a reset when that beat is offered.
  task automatic run_refill(input int id, input logic [31:0] a, input int rdy_dly,
                            input int bad_last, input int upd_beat, input logic [15:0] new_mask,
                            input logic [15:0] exp_crit, input int rst_beat);
    int w;
    w = 0;
    while (mem_req_valid !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    chk("req_valid_seen", mem_req_valid, 1);
    if (mem_req_valid !== 1'b1) return;
    chk("req_addr", mem_req_addr, a);
    chk("busy_in_req", busy, 1);
    for (int k = 0; k < rdy_dly; k++) begin
      tick();
      chk("req_hold_valid", mem_req_valid, 1);
      chk("req_hold_addr", mem_req_addr, a);
      chk("no_fill_before_hs", fill_valid, 0);
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("req_valid_drop", mem_req_valid, 0);
    chk("resp_ready_in_data", mem_resp_ready, 1);
    for (int n = 0; n < WPL; n++) begin
      if (n == 4) begin
        mem_resp_valid = 1'b0;
        tick();
        chk("gap_no_fill", fill_valid, 0);
      end
      if (n == upd_beat) mshr_word_mask_flat[id*WPL +: WPL] = new_mask;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'hA500_0000 | (id << 8) | n;
      mem_resp_last  = (n == WPL - 1) || (n == bad_last);
      if (n == rst_beat) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_last  = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_retire", retire_req, 0);
        chk("rst_fill", fill_valid, 0);
        chk("rst_resp_ready", mem_resp_ready, 0);
        chk("rst_err", err_protocol, 0);
        return;
      end
      tick();
      chk("fill_valid", fill_valid, 1);
      chk("fill_addr", fill_addr, a + 32'(4 * n));
      chk("fill_data", fill_data, 32'hA500_0000 | (id << 8) | n);
      chk("fill_critical", fill_critical, exp_crit[n]);
      chk("retire_at_last_only", retire_req, (n == WPL - 1));
      if (n == bad_last) chk("err_set", err_protocol, 1);
    end
    mem_resp_valid = 1'b0;
    mem_resp_last  = 1'b0;
    chk("retire_id", retire_id, id);
    chk("resp_ready_off", mem_resp_ready, 0);
    mshr_valid[id] = 1'b0;
    tick();
    chk("retire_once", retire_req, 0);
    chk("drain_no_fill", fill_valid, 0);
    chk("drain_busy", busy, 1);
    tick();
    chk("idle_after_drain", busy, 0);
  endtask

  initial begin
    rst                 = 1'b0;
    mshr_valid          = '0;
    mshr_addr_flat      = '0;
    mshr_word_mask_flat = '0;
    mem_req_ready       = 1'b0;
    mem_resp_valid      = 1'b0;
    mem_resp_data       = '0;
    mem_resp_last       = 1'b0;
    repeat (3) tick();
    chk("reset_busy", busy, 0);
    chk("reset_req_valid", mem_req_valid, 0);
    chk("reset_resp_ready", mem_resp_ready, 0);
    chk("reset_fill_valid", fill_valid, 0);
    chk("reset_retire", retire_req, 0);
    chk("reset_err", err_protocol, 0);
    rst = 1'b1;
    tick();
    chk("idle_no_request", busy, 0);

    // Round robin from pointer 0; entry 0 re-allocated after its first service
    set_entry(0, 32'h2000, 16'h0003);
    set_entry(1, 32'h3000, 16'h0000);
    set_entry(3, 32'h4000, 16'h8000);
    run_refill(0, 32'h2000, 0, -1, -1, 16'h0, 16'h0003, -1);
    set_entry(0, 32'h2400, 16'h0002);
    run_refill(1, 32'h3000, 0, -1, -1, 16'h0, 16'h0000, -1);
    run_refill(3, 32'h4000, 0, -1, -1, 16'h0, 16'h8000, -1);
    run_refill(0, 32'h2400, 0, -1, -1, 16'h0, 16'h0002, -1);

    // Basic refill of entry 2
    set_entry(2, 32'h1000, 16'h0001);
    run_refill(2, 32'h1000, 0, -1, -1, 16'h0, 16'h0001, -1);
    chk("err_clean", err_protocol, 0);

    // Request back-pressure
    set_entry(5, 32'h5000, 16'h00F0);
    run_refill(5, 32'h5000, 5, -1, -1, 16'h0, 16'h00F0, -1);

    // Coalesced word 8 added before beat 8
    set_entry(6, 32'h6000, 16'h0001);
    run_refill(6, 32'h6000, 0, -1, 8, 16'h0101, 16'h0101, -1);

    // Early last on beat 7
    set_entry(7, 32'h7000, 16'h0000);
    run_refill(7, 32'h7000, 0, 7, -1, 16'h0, 16'h0000, -1);
    chk("err_sticky", err_protocol, 1);

    // Reset mid-burst, then a fresh refill from beat 0
    set_entry(4, 32'h8000, 16'h0020);
    run_refill(4, 32'h8000, 0, -1, -1, 16'h0, 16'h0020, 5);
    run_refill(4, 32'h8000, 0, -1, -1, 16'h0, 16'h0020, -1);
    chk("err_after_reset", err_protocol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mshr_refill_ctrl.md
MSHR_REFILL_CTRL -- requirements
Module: mshr_refill_ctrl

Interface
REQ-001 SHALL have parameter NUM_MSHR, default 8: number of MSHR entries tracked, power of 2.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: memory beat and word width.
REQ-004 SHALL have parameter WORDS_PER_LINE, default 16: beats per refill, power of 2, at least 2.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have port mshr_valid, input, NUM_MSHR: per-entry valid flags from the MSHR file.
REQ-008 SHALL have port mshr_addr_flat, input, NUM_MSHR*ADDR_WIDTH: line-aligned address per entry.
REQ-009 SHALL have port mshr_word_mask_flat, input, NUM_MSHR*WORDS_PER_LINE: requested-word bitmap per entry.
REQ-010 SHALL have ports retire_req (output, 1) and retire_id (output, log2(NUM_MSHR), min 1): retire pulse and target entry.
REQ-011 SHALL have ports mem_req_valid (output, 1), mem_req_ready (input, 1) and mem_req_addr (output, ADDR_WIDTH): line read request.
REQ-012 SHALL have ports mem_resp_valid (input, 1), mem_resp_ready (output, 1), mem_resp_data (input, DATA_WIDTH) and mem_resp_last (input, 1): beat return.
REQ-013 SHALL have ports fill_valid (output, 1), fill_addr (output, ADDR_WIDTH), fill_data (output, DATA_WIDTH) and fill_critical (output, 1): word write into the cache array plus a requester-wakeup flag.
REQ-014 SHALL have ports busy (output, 1) and err_protocol (output, 1): status and sticky beat-count mismatch flag.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, DATA, RETIRE, DRAIN.
REQ-016 IDLE: if any mshr_valid bit is set, SHALL select one by round-robin, starting at the entry after the last one served; latch id and address; go to REQ next cycle.
REQ-017 REQ: SHALL hold mem_req_valid=1 with mem_req_addr stable until mem_req_valid and mem_req_ready are both high; then go to DATA.
REQ-018 DATA: SHALL drive mem_resp_ready=1; each accepted beat SHALL register one fill word the next cycle.
REQ-019 Fill word n SHALL carry fill_addr = line address + 4*n and fill_data = beat data, with beat counter n running 0..WORDS_PER_LINE-1.
REQ-020 fill_critical SHALL equal bit n of the selected entry's live word mask, sampled in the beat-accept cycle so coalesced words added mid-refill are woken.
REQ-021 On the accepted beat with n = WORDS_PER_LINE-1, SHALL go to RETIRE; the counter SHALL not wrap past the last beat.
REQ-022 If mem_resp_last differs from (n == WORDS_PER_LINE-1) on any accepted beat, SHALL set err_protocol; the counter SHALL still govern completion.
REQ-023 RETIRE: SHALL pulse retire_req=1 with the latched retire_id for exactly one cycle, in the same cycle as the final fill word; go to DRAIN.
REQ-024 DRAIN: SHALL idle for one cycle so the MSHR valid bit clears before the next selection; go to IDLE.
REQ-025 SHALL keep only one refill outstanding; new MSHR allocations during a refill wait for IDLE.
REQ-026 If the selected entry's mshr_valid drops before RETIRE, SHALL complete the burst and still retire, and SHALL not set err_protocol.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 mem_req_valid, mem_resp_ready, fill_valid and retire_req SHALL each be 0 outside REQ, DATA, the fill cycle and RETIRE respectively.

Reset
REQ-029 While rst=0 at a clock edge, SHALL force state IDLE, round-robin pointer 0, beat counter 0, err_protocol 0, and all output valids, ready and retire_req to 0.
REQ-030 Reset mid-refill SHALL abandon the burst without retiring; memory-side recovery is the memory model's responsibility.

Structure
REQ-031 SHALL place the FSM state encoding and the ID/offset width rules (minimum 1 bit) in a shared cache package reused by mshr.
REQ-032 SHALL instantiate the round-robin arbiter as one sub-module, rr_arbiter (request vector in, grant index out, pointer update on accept).

Verification
REQ-033 Entry 2 valid, addr 0x1000, mask 0x0001 -> mem_req_addr 0x1000; 16 beats; fill_addr 0x1000..0x103C; fill_critical only on word 0; retire_id 2 pulses once.
REQ-034 Entries 0, 1, 3 valid simultaneously -> served in order 0, 1, 3; then with 0 re-allocated, served 0 next only after 3.
REQ-035 mem_req_ready held low 5 cycles -> mem_req_valid and mem_req_addr stable throughout; no fill before the handshake.
REQ-036 Mask 0x0001 becomes 0x0101 before beat 8 -> fill_critical high on beats 0 and 8.
REQ-037 mem_resp_last asserted on beat 7 -> err_protocol=1 and sticky; retire still after beat 15.
REQ-038 rst=0 during beat 5 -> next cycle busy=0, retire_req=0, fill_valid=0; a fresh refill restarts at beat 0 after reset.
